// File: rtl/wait_event_monitor_pkg.sv
// Shared types and constants for the wait/event monitor.
// The edge select encoding matches the sel_wtr_wtf command bit.
package wait_event_pkg;

    typedef enum logic {
        WTR = 1'b0,
        WTF = 1'b1
    } wait_edge_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int C_NO_TIMEOUT = 0;

endpackage

// File: rtl/wait_event_monitor_if.sv
// Command/status bundle between the command sequencer (master) and the monitor (slave).
interface wait_event_monitor_if #(
    parameter int WAIT_SIZE = 5,
    parameter int TIMEOUT_W = 32
);
    localparam int SEL_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

    logic                 start;
    logic [SEL_W-1:0]     wait_sel;
    logic                 sel_wtr_wtf;
    logic [TIMEOUT_W-1:0] max_timeout;
    logic                 abort;
    logic                 busy;
    logic                 wait_done;
    logic                 wait_timeout;
    logic [TIMEOUT_W-1:0] elapsed;

    modport master (
        output start, wait_sel, sel_wtr_wtf, max_timeout, abort,
        input  busy, wait_done, wait_timeout, elapsed
    );

    modport slave (
        input  start, wait_sel, sel_wtr_wtf, max_timeout, abort,
        output busy, wait_done, wait_timeout, elapsed
    );

endinterface

// File: rtl/wait_event_monitor_edge_detect.sv
// Previous-level register for the watched signal and the rise/fall comparison.
// The register is seeded at arming so a level already at the target never fires.
module wait_edge_detect
    import wait_event_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic       level,
    input  wait_edge_e edge_sel,
    output logic       hit
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else if (load || advance) begin
            prev_q <= level;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (edge_sel == WTR) begin
            hit = !prev_q && level;
        end else begin
            hit = prev_q && !level;
        end
    end

endmodule

// File: rtl/wait_event_monitor.sv
// Arms on one of WAIT_SIZE signals and reports a rise/fall event or a timeout.
//   state | meaning
//   IDLE  | waiting for a start with a valid selection
//   ARMED | watching the latched signal; counting cycles toward the timeout
module wait_event_monitor
    import wait_event_pkg::*;
#(
    parameter int WAIT_SIZE  = 5,
    parameter int WAIT_WIDTH = 1,
    parameter int TIMEOUT_W  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    wait_event_monitor_if.slave             cmd,
    input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals
);

    localparam int                   SEL_W   = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    wait_edge_e           edge_q, edge_d;
    logic [TIMEOUT_W-1:0] maxt_q, maxt_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] left_q, left_d;
    logic [TIMEOUT_W-1:0] elapsed_q, elapsed_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;

    logic [WAIT_SIZE-1:0] levels;
    logic [SEL_W-1:0]     sel_mux;
    logic                 cur_level;
    logic                 sel_valid;
    logic                 arm;
    logic                 advance;
    logic                 hit;
    logic                 tmo_en;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + TIMEOUT_W'(1);
    endfunction

    always_comb begin
        levels = '0;
        for (int i = 0; i < WAIT_SIZE; i++) begin
            levels[i] = |wait_signals[i*WAIT_WIDTH +: WAIT_WIDTH];
        end
    end

    // At arming the incoming selection seeds the edge detector; afterwards the latched one.
    assign sel_mux   = (state_q == ARMED) ? sel_q : cmd.wait_sel;
    assign sel_valid = int'(cmd.wait_sel) < WAIT_SIZE;
    assign tmo_en    = maxt_q != TIMEOUT_W'(C_NO_TIMEOUT);

    always_comb begin
        cur_level = 1'b0;
        for (int i = 0; i < WAIT_SIZE; i++) begin
            if (sel_mux == SEL_W'(i)) begin
                cur_level = levels[i];
            end
        end
    end

    wait_edge_detect u_edge_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (arm),
        .advance  (advance),
        .level    (cur_level),
        .edge_sel (edge_q),
        .hit      (hit)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        edge_d    = edge_q;
        maxt_d    = maxt_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        elapsed_d = elapsed_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        arm       = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd.start && sel_valid) begin
                    state_d = ARMED;
                    sel_d   = cmd.wait_sel;
                    edge_d  = wait_edge_e'(cmd.sel_wtr_wtf);
                    maxt_d  = cmd.max_timeout;
                    cnt_d   = '0;
                    left_d  = cmd.max_timeout;
                    arm     = 1'b1;
                end
            end
            ARMED: begin
                // Priority: abort, then event, then timeout.
                if (cmd.abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    elapsed_d = sat_inc(cnt_q);
                end else if (tmo_en && (left_q == TIMEOUT_W'(1))) begin
                    state_d   = IDLE;
                    tmo_d     = 1'b1;
                    elapsed_d = maxt_q;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                    advance = 1'b1;
                    if (tmo_en) begin
                        left_d = left_q - TIMEOUT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            edge_q    <= WTR;
            maxt_q    <= '0;
            cnt_q     <= '0;
            left_q    <= '0;
            elapsed_q <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            edge_q    <= edge_d;
            maxt_q    <= maxt_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            elapsed_q <= elapsed_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cmd.busy         = (state_q == ARMED);
    assign cmd.wait_done    = done_q;
    assign cmd.wait_timeout = tmo_q;
    assign cmd.elapsed      = elapsed_q;

endmodule

// File: tb/tb_wait_event_monitor.sv
// Scoreboard bench for wait_event_monitor: expected completions are queued at stimulus time
// and matched (kind, elapsed, cycle) against the pulses the monitor produces.
module tb_wait_event_monitor;

    typedef struct {
        bit is_done;
        int elapsed;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] sig;
    int         cyc;
    int         checks;
    int         errors;
    exp_t       sb[$];
    exp_t       mon_e;

    wait_event_monitor_if #(.WAIT_SIZE(5), .TIMEOUT_W(32)) cmd_if ();

    wait_event_monitor #(
        .WAIT_SIZE  (5),
        .WAIT_WIDTH (1),
        .TIMEOUT_W  (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd_if),
        .wait_signals (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm(input int sel, input bit edge_sel, input int mt, output int a);
        @(posedge clk);
        #1;
        cmd_if.start       = 1'b1;
        cmd_if.wait_sel    = 3'(sel);
        cmd_if.sel_wtr_wtf = edge_sel;
        cmd_if.max_timeout = 32'(mt);
        @(posedge clk);
        #1;
        cmd_if.start = 1'b0;
        a = cyc;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (cmd_if.busy && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle", cmd_if.busy, 0);
    endtask

    task automatic push(input bit is_done, input int el, input int c);
        exp_t e;
        e.is_done = is_done;
        e.elapsed = el;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (cmd_if.wait_done || cmd_if.wait_timeout)) begin
            chk("pulse_excl", cmd_if.wait_done & cmd_if.wait_timeout, 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {cmd_if.wait_done, cmd_if.wait_timeout}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", {cmd_if.wait_done, cmd_if.wait_timeout},
                    mon_e.is_done ? 2'b10 : 2'b01);
                chk("elapsed", cmd_if.elapsed, mon_e.elapsed);
                chk("pulse_cyc", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog busy=%0d exp=0", cmd_if.busy);
        $fatal(1);
    end

    initial begin
        int a;
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        sig                = '0;
        cmd_if.start       = 1'b0;
        cmd_if.wait_sel    = '0;
        cmd_if.sel_wtr_wtf = 1'b0;
        cmd_if.max_timeout = '0;
        cmd_if.abort       = 1'b0;
        #12;
        chk("rst_busy", cmd_if.busy, 0);
        chk("rst_done", cmd_if.wait_done, 0);
        chk("rst_tmo", cmd_if.wait_timeout, 0);
        chk("rst_elapsed", cmd_if.elapsed, 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // WTR on signal 0, rise sampled 3 edges after arming
        arm(0, 1'b0, 10, a);
        chk("busy_armed", cmd_if.busy, 1);
        push(1'b1, 3, a + 3);
        step(2);
        sig[0] = 1'b1;
        wait_idle(20);

        // WTF on signal 2, fall on the first armed edge
        sig[2] = 1'b1;
        arm(2, 1'b1, 10, a);
        push(1'b1, 1, a + 1);
        sig[2] = 1'b0;
        wait_idle(20);

        // timeout on static signal 4
        arm(4, 1'b0, 5, a);
        push(1'b0, 5, a + 5);
        wait_idle(20);

        // level already high, ignored restart, abort racing a rise
        sig[1] = 1'b1;
        arm(1, 1'b0, 0, a);
        step(2);
        cmd_if.start       = 1'b1;
        cmd_if.wait_sel    = 3'd3;
        cmd_if.max_timeout = 32'd2;
        step(1);
        cmd_if.start = 1'b0;
        step(4);
        chk("level_no_fire", cmd_if.busy, 1);
        sig[1] = 1'b0;
        step(1);
        cmd_if.abort = 1'b1;
        sig[1]       = 1'b1;
        step(1);
        cmd_if.abort = 1'b0;
        chk("abort_busy", cmd_if.busy, 0);
        chk("abort_elapsed", cmd_if.elapsed, 5);
        step(3);
        sig[1] = 1'b0;
        arm(1, 1'b0, 20, a);
        push(1'b1, 2, a + 2);
        step(1);
        sig[1] = 1'b1;
        wait_idle(20);

        // out-of-range selection is ignored
        step(1);
        cmd_if.start    = 1'b1;
        cmd_if.wait_sel = 3'd5;
        step(1);
        cmd_if.start = 1'b0;
        chk("bad_sel", cmd_if.busy, 0);
        step(3);

        // restart in the cycle the timeout pulse is high
        arm(4, 1'b0, 2, a);
        push(1'b0, 2, a + 2);
        step(2);
        chk("b2b_pulse", cmd_if.wait_timeout, 1);
        cmd_if.start       = 1'b1;
        cmd_if.wait_sel    = 3'd4;
        cmd_if.sel_wtr_wtf = 1'b0;
        cmd_if.max_timeout = 32'd3;
        step(1);
        cmd_if.start = 1'b0;
        chk("b2b_busy", cmd_if.busy, 1);
        push(1'b0, 3, cyc + 3);
        wait_idle(20);

        // no timeout, event after 1000 cycles
        sig[3] = 1'b0;
        arm(3, 1'b0, 0, a);
        push(1'b1, 1000, a + 1000);
        step(999);
        sig[3] = 1'b1;
        wait_idle(10);

        // event on the same edge the timeout would expire
        sig[0] = 1'b1;
        arm(0, 1'b1, 4, a);
        push(1'b1, 4, a + 4);
        step(3);
        sig[0] = 1'b0;
        wait_idle(20);

        // reset while armed
        arm(0, 1'b0, 0, a);
        step(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", cmd_if.busy, 0);
        chk("midrst_done", cmd_if.wait_done, 0);
        chk("midrst_tmo", cmd_if.wait_timeout, 0);
        chk("midrst_elapsed", cmd_if.elapsed, 0);
        sig[0] = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(5);
        chk("post_rst_busy", cmd_if.busy, 0);

        step(2);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
